// File: rtl/duck_draw_if.sv
// Request/acknowledge link between the duck motion sequencer and the shared pixel drawer.
interface duck_draw_if #(
  parameter int unsigned X_W = 8,
  parameter int unsigned Y_W = 7
);
  logic           draw_req;
  logic           draw_erase;
  logic [1:0]     draw_id;
  logic [X_W-1:0] draw_x;
  logic [Y_W-1:0] draw_y;
  logic           draw_done;

  modport master (
    output draw_req, draw_erase, draw_id, draw_x, draw_y,
    input  draw_done
  );

  modport slave (
    input  draw_req, draw_erase, draw_id, draw_x, draw_y,
    output draw_done
  );
endinterface

// File: rtl/duck_motion_ctrl.sv
// Multi-duck movement controller: per tick, walks every duck through erase/update/draw
// against the shared pixel drawer, applying flight, bounce, fall and fly-off rules.
module duck_motion_ctrl #(
  parameter int unsigned N_DUCKS   = 2,
  parameter int unsigned X_W       = 8,
  parameter int unsigned Y_W       = 7,
  parameter int unsigned X_MAX     = 152,
  parameter int unsigned Y_MAX     = 112,
  parameter int unsigned STEP      = 2,
  parameter int unsigned SPAWN_X   = 16,
  parameter int unsigned SPAWN_GAP = 40
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   tick_i,
  input  logic                   round_start_i,
  input  logic [2*N_DUCKS-1:0]   rand_dir_i,
  input  logic [N_DUCKS-1:0]     shot_i,
  input  logic                   escape_i,
  duck_draw_if.master            draw,
  output logic [N_DUCKS-1:0]     alive_o,
  output logic [N_DUCKS-1:0]     fell_o,
  output logic [N_DUCKS-1:0]     escaped_o,
  output logic                   round_over_o,
  output logic                   tick_overrun_o
);

  localparam int unsigned IDX_W = (N_DUCKS > 1) ? $clog2(N_DUCKS) : 1;

  localparam logic [X_W:0]   STEP_XW = (X_W+1)'(STEP);
  localparam logic [X_W:0]   XMAX_XW = (X_W+1)'(X_MAX);
  localparam logic [Y_W:0]   STEP_YW = (Y_W+1)'(STEP);
  localparam logic [Y_W:0]   YMAX_YW = (Y_W+1)'(Y_MAX);
  localparam logic [X_W-1:0] STEP_X  = X_W'(STEP);
  localparam logic [Y_W-1:0] STEP_Y  = Y_W'(STEP);

  typedef enum logic [2:0] {M_IDLE, M_FLY, M_FALL, M_ESC, M_GONE} mode_e;
  typedef enum logic [2:0] {S_WAIT, S_ERASE, S_UPDATE, S_DRAW, S_NEXT} seq_e;

  seq_e               seq_q;
  logic [IDX_W-1:0]   idx_q;
  mode_e              mode_q [N_DUCKS];
  logic [X_W-1:0]     x_q    [N_DUCKS];
  logic [Y_W-1:0]     y_q    [N_DUCKS];
  logic [N_DUCKS-1:0] flip_q, pshot_q, pesc_q, alive_q, fell_q, escaped_q;
  logic               round_over_q, overrun_q, rs_pend_q, tick_hold_q;
  logic               req_q, erase_q;
  logic [1:0]         id_q;
  logic [X_W-1:0]     dx_q;
  logic [Y_W-1:0]     dy_q;

  mode_e              nm;
  logic [X_W-1:0]     nx;
  logic [Y_W-1:0]     ny;
  logic               nflip, nfell, nesc, go_right, go_down, all_gone;
  logic [N_DUCKS-1:0] pshot_d, pesc_d;
  logic [IDX_W-1:0]   nxt_idx;

  // Next position/mode of the duck currently selected by the sequencer.
  always_comb begin
    nm       = mode_q[idx_q];
    nx       = x_q[idx_q];
    ny       = y_q[idx_q];
    nflip    = flip_q[idx_q];
    nfell    = 1'b0;
    nesc     = 1'b0;
    go_right = 1'b0;
    go_down  = 1'b0;
    if (pshot_q[idx_q] && (nm == M_FLY || nm == M_ESC)) nm = M_FALL;
    else if (pesc_q[idx_q] && nm == M_FLY)              nm = M_ESC;
    go_right = rand_dir_i[{idx_q, 1'b0}] ^ nflip;
    go_down  = rand_dir_i[{idx_q, 1'b1}];
    case (nm)
      M_FLY: begin
        if (go_right) begin
          if ((X_W+1)'(nx) + STEP_XW > XMAX_XW) begin
            nx    = X_W'(X_MAX);
            nflip = ~nflip;
          end else nx = nx + STEP_X;
        end else begin
          if (nx < STEP_X) begin
            nx    = '0;
            nflip = ~nflip;
          end else nx = nx - STEP_X;
        end
        if (go_down) ny = ((Y_W+1)'(ny) + STEP_YW > YMAX_YW) ? Y_W'(Y_MAX) : ny + STEP_Y;
        else         ny = (ny < STEP_Y) ? '0 : ny - STEP_Y;
      end
      M_FALL: begin
        if ((Y_W+1)'(ny) + STEP_YW >= YMAX_YW) begin
          ny    = Y_W'(Y_MAX);
          nm    = M_GONE;
          nfell = 1'b1;
        end else ny = ny + STEP_Y;
      end
      M_ESC: begin
        if (ny < STEP_Y) begin
          nm   = M_GONE;
          nesc = 1'b1;
        end else ny = ny - STEP_Y;
      end
      default: ;
    endcase
  end

  // Pending hit/escape latches, consumed when their duck is updated.
  always_comb begin
    pshot_d  = pshot_q;
    pesc_d   = pesc_q;
    all_gone = 1'b1;
    nxt_idx  = idx_q + IDX_W'(1);
    if (seq_q == S_UPDATE) begin
      pshot_d[idx_q] = 1'b0;
      pesc_d[idx_q]  = 1'b0;
    end
    for (int i = 0; i < N_DUCKS; i++) begin
      if (shot_i[i] && (mode_q[i] inside {M_FLY, M_FALL, M_ESC})) pshot_d[i] = 1'b1;
      if (escape_i && mode_q[i] == M_FLY) pesc_d[i] = 1'b1;
      if (mode_q[i] != M_GONE) all_gone = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seq_q        <= S_WAIT;
      idx_q        <= '0;
      flip_q       <= '0;
      pshot_q      <= '0;
      pesc_q       <= '0;
      alive_q      <= '0;
      fell_q       <= '0;
      escaped_q    <= '0;
      round_over_q <= 1'b0;
      overrun_q    <= 1'b0;
      rs_pend_q    <= 1'b0;
      tick_hold_q  <= 1'b0;
      req_q        <= 1'b0;
      erase_q      <= 1'b0;
      id_q         <= '0;
      dx_q         <= '0;
      dy_q         <= '0;
      for (int i = 0; i < N_DUCKS; i++) begin
        mode_q[i] <= M_IDLE;
        x_q[i]    <= '0;
        y_q[i]    <= '0;
      end
    end else begin
      pshot_q <= pshot_d;
      pesc_q  <= pesc_d;
      if (all_gone) round_over_q <= 1'b1;
      if (seq_q != S_WAIT) begin
        if (tick_i)        overrun_q <= 1'b1;
        if (round_start_i) rs_pend_q <= 1'b1;
      end
      case (seq_q)
        S_WAIT: begin
          if (round_start_i || rs_pend_q) begin
            // Spawn costs this cycle; a coincident tick is replayed on the next one.
            rs_pend_q    <= 1'b0;
            tick_hold_q  <= tick_i;
            pshot_q      <= '0;
            pesc_q       <= '0;
            flip_q       <= '0;
            fell_q       <= '0;
            escaped_q    <= '0;
            round_over_q <= 1'b0;
            alive_q      <= '1;
            for (int i = 0; i < N_DUCKS; i++) begin
              mode_q[i] <= M_FLY;
              x_q[i]    <= X_W'(SPAWN_X + SPAWN_GAP * i);
              y_q[i]    <= Y_W'(Y_MAX);
            end
          end else if (tick_i || tick_hold_q) begin
            tick_hold_q <= 1'b0;
            idx_q       <= '0;
            req_q       <= alive_q[0];
            erase_q     <= 1'b1;
            id_q        <= '0;
            dx_q        <= x_q[0];
            dy_q        <= y_q[0];
            seq_q       <= S_ERASE;
          end
        end
        S_ERASE: begin
          if (!alive_q[idx_q]) seq_q <= S_NEXT;
          else if (draw.draw_done) begin
            req_q <= 1'b0;
            seq_q <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          mode_q[idx_q]  <= nm;
          x_q[idx_q]     <= nx;
          y_q[idx_q]     <= ny;
          flip_q[idx_q]  <= nflip;
          alive_q[idx_q] <= (nm != M_GONE);
          if (nfell) fell_q[idx_q]    <= 1'b1;
          if (nesc)  escaped_q[idx_q] <= 1'b1;
          if (nm == M_GONE) seq_q <= S_NEXT;
          else begin
            req_q   <= 1'b1;
            erase_q <= 1'b0;
            dx_q    <= nx;
            dy_q    <= ny;
            seq_q   <= S_DRAW;
          end
        end
        S_DRAW: begin
          if (draw.draw_done) begin
            req_q <= 1'b0;
            seq_q <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (idx_q == IDX_W'(N_DUCKS - 1)) seq_q <= S_WAIT;
          else begin
            idx_q   <= nxt_idx;
            req_q   <= alive_q[nxt_idx];
            erase_q <= 1'b1;
            id_q    <= 2'(nxt_idx);
            dx_q    <= x_q[nxt_idx];
            dy_q    <= y_q[nxt_idx];
            seq_q   <= S_ERASE;
          end
        end
        default: seq_q <= S_WAIT;
      endcase
    end
  end

  assign draw.draw_req   = req_q;
  assign draw.draw_erase = erase_q;
  assign draw.draw_id    = id_q;
  assign draw.draw_x     = dx_q;
  assign draw.draw_y     = dy_q;
  assign alive_o         = alive_q;
  assign fell_o          = fell_q;
  assign escaped_o       = escaped_q;
  assign round_over_o    = round_over_q;
  assign tick_overrun_o  = overrun_q;

endmodule

// File: tb/tb_duck_motion_ctrl.sv
// Randomized bench for duck_motion_ctrl: a transaction-level duck model predicts every
// draw request and the status flags after each movement tick.
module tb_duck_motion_ctrl;
  localparam int N = 2;
  localparam int XMAX = 152, YMAX = 112, STEP = 2;
  localparam int MD_IDLE = 0, MD_FLY = 1, MD_FALL = 2, MD_ESC = 3, MD_GONE = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0, round_start = 1'b0, escape = 1'b0;
  logic [3:0] rand_dir = '0;
  logic [1:0] shot = '0;
  logic [1:0] alive, fell, escaped;
  logic       round_over, tick_overrun;

  duck_draw_if #(.X_W(8), .Y_W(7)) dif ();

  duck_motion_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .tick_i         (tick),
    .round_start_i  (round_start),
    .rand_dir_i     (rand_dir),
    .shot_i         (shot),
    .escape_i       (escape),
    .draw           (dif),
    .alive_o        (alive),
    .fell_o         (fell),
    .escaped_o      (escaped),
    .round_over_o   (round_over),
    .tick_overrun_o (tick_overrun)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  int  m_mode [N];
  int  m_x    [N];
  int  m_y    [N];
  bit  m_rev  [N];
  bit  m_ps   [N];
  bit  m_pe   [N];
  bit  m_fell [N];
  bit  m_esc  [N];
  bit  m_over, m_overrun;
  logic [17:0] expq [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_alive(input int i);
    return m_mode[i] == MD_FLY || m_mode[i] == MD_FALL || m_mode[i] == MD_ESC;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_mode[i] = MD_IDLE; m_x[i] = 0; m_y[i] = 0; m_rev[i] = 0;
      m_ps[i] = 0; m_pe[i] = 0; m_fell[i] = 0; m_esc[i] = 0;
    end
    m_over = 0; m_overrun = 0;
  endfunction

  function automatic void m_spawn();
    for (int i = 0; i < N; i++) begin
      m_mode[i] = MD_FLY; m_x[i] = 16 + 40 * i; m_y[i] = YMAX; m_rev[i] = 0;
      m_ps[i] = 0; m_pe[i] = 0; m_fell[i] = 0; m_esc[i] = 0;
    end
    m_over = 0;
  endfunction

  function automatic void m_shot(input logic [1:0] s);
    for (int i = 0; i < N; i++) if (s[i] && m_alive(i)) m_ps[i] = 1;
  endfunction

  function automatic void m_escape();
    for (int i = 0; i < N; i++) if (m_mode[i] == MD_FLY) m_pe[i] = 1;
  endfunction

  // One movement tick: queue the expected drawer traffic and advance every duck.
  function automatic void m_tick(input logic [3:0] rd);
    bit gone_all;
    expq.delete();
    for (int i = 0; i < N; i++) begin
      bit right, down;
      right = rd[2*i] ^ m_rev[i];
      down  = rd[2*i+1];
      if (!m_alive(i)) continue;
      expq.push_back({1'b1, 2'(i), 8'(m_x[i]), 7'(m_y[i])});
      if (m_ps[i]) m_mode[i] = MD_FALL;
      else if (m_pe[i] && m_mode[i] == MD_FLY) m_mode[i] = MD_ESC;
      m_ps[i] = 0; m_pe[i] = 0;
      case (m_mode[i])
        MD_FLY: begin
          if (right && m_x[i] + STEP > XMAX) begin m_x[i] = XMAX; m_rev[i] = !m_rev[i]; end
          else if (!right && m_x[i] < STEP)  begin m_x[i] = 0;    m_rev[i] = !m_rev[i]; end
          else m_x[i] = right ? m_x[i] + STEP : m_x[i] - STEP;
          if (down) m_y[i] = (m_y[i] + STEP > YMAX) ? YMAX : m_y[i] + STEP;
          else      m_y[i] = (m_y[i] < STEP) ? 0 : m_y[i] - STEP;
        end
        MD_FALL: begin
          m_y[i] = m_y[i] + STEP;
          if (m_y[i] >= YMAX) begin m_y[i] = YMAX; m_mode[i] = MD_GONE; m_fell[i] = 1; end
        end
        MD_ESC: begin
          if (m_y[i] < STEP) begin m_mode[i] = MD_GONE; m_esc[i] = 1; end
          else m_y[i] = m_y[i] - STEP;
        end
        default: ;
      endcase
      if (m_mode[i] != MD_GONE) expq.push_back({1'b0, 2'(i), 8'(m_x[i]), 7'(m_y[i])});
    end
    gone_all = 1;
    for (int i = 0; i < N; i++) if (m_mode[i] != MD_GONE) gone_all = 0;
    if (gone_all) m_over = 1;
  endfunction

  function automatic logic [17:0] cur_req();
    return {dif.draw_erase, dif.draw_id, dif.draw_x, dif.draw_y};
  endfunction

  task automatic check_flags();
    logic [1:0] ea, ef, ee;
    for (int i = 0; i < N; i++) begin
      ea[i] = m_alive(i); ef[i] = m_fell[i]; ee[i] = m_esc[i];
    end
    check("alive", alive, ea);
    check("fell", fell, ef);
    check("escaped", escaped, ee);
    check("round_over", round_over, m_over);
    check("tick_overrun", tick_overrun, m_overrun);
  endtask

  task automatic clear_inputs();
    tick = 0; round_start = 0; escape = 0; shot = '0;
  endtask

  task automatic pulse_rs();
    @(negedge clk); round_start = 1;
    @(negedge clk); round_start = 0;
    m_spawn();
  endtask

  task automatic pulse_shot(input logic [1:0] s);
    @(negedge clk); shot = s;
    @(negedge clk); shot = '0;
    m_shot(s);
  endtask

  task automatic pulse_esc();
    @(negedge clk); escape = 1;
    @(negedge clk); escape = 0;
    m_escape();
  endtask

  task automatic pulse_stray_done();
    @(negedge clk); dif.draw_done = 1;
    @(negedge clk); dif.draw_done = 0;
  endtask

  // Issue one tick, answer every draw request after lat cycles, and optionally
  // inject shot/escape/tick/round_start while the first request is outstanding.
  task automatic run_tick(input logic [3:0] rd, input int lat, input logic [1:0] inj_shot,
                          input bit inj_esc, input bit inj_tick, input bit inj_rs, input bit with_rs);
    bit any, first0, inj_pending, stable, seen;
    int n, got, guard;
    logic [17:0] obs;
    rand_dir = rd;
    if (with_rs) m_spawn();
    any = 0;
    for (int i = 0; i < N; i++) if (m_alive(i)) any = 1;
    first0 = m_alive(0);
    if (any) begin
      m_shot(inj_shot);
      if (inj_esc)  m_escape();
      if (inj_tick) m_overrun = 1;
    end
    m_tick(rd);
    if (any && inj_rs) m_spawn();
    n = expq.size();
    inj_pending = any && (inj_shot != 0 || inj_esc || inj_tick || inj_rs);

    @(negedge clk); tick = 1; round_start = with_rs;
    @(negedge clk); tick = 0; round_start = 0;
    if (first0 && !with_rs) check("req_latency", dif.draw_req, 1);
    got = 0; guard = 0;
    while (got < n && guard < 400) begin
      if (dif.draw_req) begin
        obs = cur_req();
        stable = 1;
        if (inj_pending) begin
          shot = inj_shot; escape = inj_esc; tick = inj_tick; round_start = inj_rs;
          inj_pending = 0;
        end
        for (int k = 0; k < lat; k++) begin
          @(negedge clk); clear_inputs();
          if (cur_req() !== obs || dif.draw_req !== 1'b1) stable = 0;
        end
        dif.draw_done = 1;
        @(negedge clk); clear_inputs(); dif.draw_done = 0;
        check($sformatf("req%0d", got), obs, expq[got]);
        check("req_stable", stable, 1);
        check("req_drop", dif.draw_req, 0);
        got++;
      end else begin
        @(negedge clk); guard++;
      end
    end
    check("req_count", got, n);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (dif.draw_req) seen = 1;
    end
    check("idle_after_seq", seen, 0);
    check_flags();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    dif.draw_done = 0;
    m_reset();
    repeat (3) @(negedge clk);
    check("rst_req", dif.draw_req, 0);
    check_flags();
    reset_n = 1;

    // Idle ducks ignore hits, stray acknowledges and ticks.
    pulse_shot(2'b11);
    pulse_stray_done();
    run_tick(4'b0101, 3, 2'b00, 0, 0, 0, 0);

    // Round 1: right/up until duck 0 bounces off the right wall.
    pulse_rs();
    @(negedge clk);
    check_flags();
    run_tick(4'b0101, 3, 2'b00, 0, 0, 0, 0);
    repeat (72) run_tick(4'b0101, $urandom_range(0, 3), 2'b00, 0, 0, 0, 0);

    // Round 2: climb to y=4, then escape through the top.
    pulse_rs();
    repeat (54) run_tick(4'b0101, $urandom_range(0, 3), 2'b00, 0, 0, 0, 0);
    pulse_esc();
    repeat (4) run_tick(4'b0101, 1, 2'b00, 0, 0, 0, 0);

    // Round 3: spawn and tick together, hit mid-erase, fall to the ground.
    run_tick(4'b0101, 2, 2'b00, 0, 0, 0, 1);
    repeat (9) run_tick(4'b0101, 1, 2'b00, 0, 0, 0, 0);
    run_tick(4'b0101, 3, 2'b01, 0, 0, 0, 0);
    repeat (10) run_tick(4'b1010, $urandom_range(0, 3), 2'b00, 0, 0, 0, 0);
    run_tick(4'b0110, 2, 2'b00, 0, 1, 0, 0);
    run_tick(4'b1001, 2, 2'b00, 0, 0, 1, 0);

    // Random play.
    repeat (150) begin
      if (m_over || $urandom_range(0, 39) == 0) pulse_rs();
      if ($urandom_range(0, 7) == 0) pulse_shot(2'($urandom));
      if ($urandom_range(0, 19) == 0) pulse_esc();
      if ($urandom_range(0, 9) == 0) pulse_stray_done();
      run_tick(4'($urandom), $urandom_range(0, 3),
               ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00,
               $urandom_range(0, 29) == 0, $urandom_range(0, 19) == 0,
               $urandom_range(0, 29) == 0, $urandom_range(0, 29) == 0);
    end

    // Asynchronous reset while a request is outstanding.
    pulse_rs();
    rand_dir = 4'b0101;
    @(negedge clk); tick = 1;
    @(negedge clk); tick = 0;
    for (int k = 0; k < 20 && !dif.draw_req; k++) @(negedge clk);
    check("rst_wait_req", dif.draw_req, 1);
    #2 reset_n = 0;
    #1;
    m_reset();
    check("rst_mid_req", dif.draw_req, 0);
    check_flags();
    @(negedge clk); reset_n = 1;
    run_tick(4'b0101, 1, 2'b00, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
